wavetable_interpolator: RTL and testbench

WAVETABLE_INTERPOLATOR -- requirements
Module: wavetable_interpolator

---
 rtl/wavetable_interpolator.sv | 109 ++++++++++
 tb/tb_wavetable_interpolator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wavetable_interpolator.sv
// ============================================================================
// Module   : wavetable_interpolator
// Purpose  : Two-point linear interpolation between adjacent wavetable words
//            read through a 1-cycle-latency ROM port; one sample per Start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wavetable_interpolator (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [11:0]        wavetableAddr,
    input  logic [19:0]        interp,
    output logic [11:0]        romAddr,
    input  logic signed [15:0] romData,
    output logic signed [15:0] sampleOut,
    output logic               sampleValid,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CAP1 = 3'd3,
        MUL  = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [11:0]         r_addr_a;
    logic [19:0]         r_frac;
    logic signed [15:0]  r_s0;
    logic signed [15:0]  r_s1;
    logic signed [37:0]  r_prod;

    logic signed [16:0]  w_diff;
    logic signed [20:0]  w_frac_s;
    logic signed [37:0]  w_prod;
    logic signed [15:0]  w_sample;

    // Full-precision product; the result always lies between s0 and s1, so
    // keeping only the low 16 bits of the sum is exact.
    assign w_diff   = $signed({r_s1[15], r_s1}) - $signed({r_s0[15], r_s0});
    assign w_frac_s = $signed({1'b0, r_frac});
    assign w_prod   = 38'(w_diff) * 38'(w_frac_s);
    assign w_sample = r_s0 + 16'(r_prod >>> 20);

    assign busy = (r_state != IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_next = RD0;
            RD0:     w_next = RD1;
            RD1:     w_next = CAP1;
            CAP1:    w_next = MUL;
            MUL:     w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_addr_a    <= 12'd0;
            r_frac      <= 20'd0;
            r_s0        <= 16'sd0;
            r_s1        <= 16'sd0;
            r_prod      <= 38'sd0;
            romAddr     <= 12'd0;
            sampleOut   <= 16'sd0;
            sampleValid <= 1'b0;
        end else begin
            sampleValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_addr_a <= wavetableAddr;
                        r_frac   <= interp;
                        romAddr  <= wavetableAddr;
                    end
                end
                RD0:  romAddr <= r_addr_a + 12'd1;
                RD1:  r_s0    <= romData;
                CAP1: r_s1    <= romData;
                MUL:  r_prod  <= w_prod;
                OUT: begin
                    sampleOut   <= w_sample;
                    sampleValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wavetable_interpolator.sv
// ============================================================================
// Module   : tb_wavetable_interpolator
// Purpose  : Self-checking bench: directed corner cases plus random operations
//            against an arithmetic interpolation model and a 1-cycle ROM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wavetable_interpolator;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Start;
    logic [11:0]        wavetableAddr;
    logic [19:0]        interp;
    logic [11:0]        romAddr;
    logic signed [15:0] romData;
    logic [15:0]        sampleOut;
    logic               sampleValid;
    logic               busy;

    logic [15:0] rom [0:4095];
    logic [15:0] last_out;
    int          n_vec = 0;
    int          n_err = 0;

    wavetable_interpolator dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .wavetableAddr (wavetableAddr),
        .interp        (interp),
        .romAddr       (romAddr),
        .romData       (romData),
        .sampleOut     (sampleOut),
        .sampleValid   (sampleValid),
        .busy          (busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) romData <= rom[romAddr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // s0 + floor((s1 - s0) * F / 2^20)
    function automatic logic [15:0] ref_interp(input int s0, input int s1, input int f);
        longint num;
        longint q;
        num = longint'(s1 - s0) * longint'(f);
        if (num >= 0) q = num / 1048576;
        else          q = -((-num + 1048575) / 1048576);
        return 16'(longint'(s0) + q);
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Start is driven in the current cycle (c); returns in cycle c+6.
    task automatic run_op(input logic [11:0] a, input logic [19:0] f, input bit poke);
        logic [11:0] a1;
        logic [15:0] exp;
        a1  = a + 12'd1;
        exp = ref_interp(int'($signed(rom[a])), int'($signed(rom[a1])), int'(f));
        Start         = 1'b1;
        wavetableAddr = a;
        interp        = f;
        for (int k = 1; k <= 6; k++) begin
            step();
            Start         = 1'b0;
            wavetableAddr = 12'($urandom);
            interp        = 20'($urandom);
            if (poke && k == 2) Start = 1'b1;
            check_val("busy", 32'(busy), 32'(k <= 5));
            check_val("sampleValid", 32'(sampleValid), 32'(k == 6));
            check_val("romAddr", 32'(romAddr), 32'((k == 1) ? a : a1));
            if (k < 6) check_val("sampleOut_hold", 32'(sampleOut), 32'(last_out));
            else       check_val("sampleOut", 32'(sampleOut), 32'(exp));
        end
        last_out = exp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_val("idle_valid", 32'(sampleValid), 32'd0);
            check_val("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 16'(i * 7);
        Reset = 1'b1; Start = 1'b0; wavetableAddr = 12'd0; interp = 20'd0;
        last_out = 16'd0;
        step();
        step();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_valid", 32'(sampleValid), 32'd0);
        check_val("rst_romAddr", 32'(romAddr), 32'd0);
        check_val("rst_sampleOut", 32'(sampleOut), 32'd0);

        // Start in the very first cycle with Reset low
        Reset = 1'b0;
        rom[10] = 16'd1000; rom[11] = 16'd2000;
        run_op(12'd10, 20'h00000, 1'b0);
        check_val("f0_exact", 32'(last_out), 32'd1000);
        idle(2);
        run_op(12'd10, 20'h80000, 1'b0);

        rom[4095] = 16'hFF9C; rom[0] = 16'd300;
        run_op(12'd4095, 20'h40000, 1'b0);

        rom[200] = 16'd5; rom[201] = 16'd4;
        run_op(12'd200, 20'h80000, 1'b0);
        rom[300] = 16'h8000; rom[301] = 16'h7FFF;
        run_op(12'd300, 20'hFFFFF, 1'b0);

        // Start while busy is ignored, then back-to-back acceptance at c+6
        run_op(12'd10, 20'h80000, 1'b1);
        run_op(12'd200, 20'h80000, 1'b0);

        // Reset in flight at c+3
        Start = 1'b1; wavetableAddr = 12'd10; interp = 20'h80000;
        step(); Start = 1'b0;
        step();
        step(); Reset = 1'b1;
        step(); Reset = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_sampleOut", 32'(sampleOut), 32'd0);
        check_val("abort_romAddr", 32'(romAddr), 32'd0);
        check_val("abort_valid", 32'(sampleValid), 32'd0);
        last_out = 16'd0;
        idle(6);

        for (int n = 0; n < 60; n++) begin
            logic [11:0] a;
            logic [19:0] f;
            a = 12'($urandom);
            f = 20'($urandom);
            rom[a]         = 16'($urandom);
            rom[a + 12'd1] = 16'($urandom);
            if (n % 10 == 0) f = 20'd0;
            if (n % 10 == 1) f = 20'hFFFFF;
            run_op(a, f, 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
